// File: rtl/floo_vc_credit_alloc.sv
// floo_vc_credit_alloc
// Per-output-port virtual-channel controller. It tracks downstream credits
// per VC and picks a VC for each requesting input port: the preferred VC
// first, otherwise the lowest-index allocatable VC. Competing input ports
// are arbitrated round-robin, one grant per cycle. A granted VC stays locked
// to its packet until the tail flit leaves.
//
// Optional feature macro: FLOO_VC_ALLOC_STRICT_PREF_EN
//   When defined, fallback is disabled and a requester waits until its
//   preferred VC is allocatable.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   alloc_req_i        per input port: head flit requests a VC
//   alloc_pref_vc_i    per input port: preferred VC (packed, NumVCWidth each)
//   alloc_gnt_o        one-hot grant (combinational)
//   alloc_vc_o         VC assigned to the granted requester
//   flit_valid_i       a flit leaves this port this cycle
//   flit_vc_i          VC of the departing flit
//   flit_last_i        departing flit is a tail flit
//   credit_valid_i     one returned credit per VC
//   credit_counter_o   current credits (packed, VCDepthWidth each)
//   vc_locked_o        VC owned by an in-flight packet
module floo_vc_credit_alloc #(
  parameter int NumReq       = 4,
  parameter int NumVC        = 4,
  parameter int NumVCWidth   = NumVC > 1 ? $clog2(NumVC) : 1,
  parameter int VCDepth      = 2,
  parameter int VCDepthWidth = $clog2(VCDepth + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq-1:0]               alloc_req_i,
  input  logic [NumReq*NumVCWidth-1:0]    alloc_pref_vc_i,
  output logic [NumReq-1:0]               alloc_gnt_o,
  output logic [NumVCWidth-1:0]           alloc_vc_o,
  input  logic                            flit_valid_i,
  input  logic [NumVCWidth-1:0]           flit_vc_i,
  input  logic                            flit_last_i,
  input  logic [NumVC-1:0]                credit_valid_i,
  output logic [NumVC*VCDepthWidth-1:0]   credit_counter_o,
  output logic [NumVC-1:0]                vc_locked_o
);

  localparam int ReqIdxW = NumReq > 1 ? $clog2(NumReq) : 1;
  localparam logic [VCDepthWidth-1:0] Depth = VCDepthWidth'(VCDepth);

  logic [VCDepthWidth-1:0] cnt_q [NumVC];
  logic [VCDepthWidth-1:0] cnt_d [NumVC];
  logic [NumVC-1:0]        lock_q, lock_d;
  logic [ReqIdxW-1:0]      ptr_q, ptr_d;

  logic [NumVC-1:0]        vc_avail;
  logic [NumVC-1:0]        vc_send;
  logic [NumReq-1:0]       elig;
  logic [NumVCWidth-1:0]   sel_vc [NumReq];
  logic [NumVCWidth-1:0]   pref;
  logic                    gnt_valid;
  logic [ReqIdxW-1:0]      win;
  logic [ReqIdxW-1:0]      cand;
  logic [NumVCWidth-1:0]   gnt_vc;
  logic [NumReq-1:0]       gnt;
  int                      rr_idx;

  always_comb begin
    for (int v = 0; v < NumVC; v++) begin
      vc_avail[v] = !lock_q[v] && (cnt_q[v] != '0);
      vc_send[v]  = flit_valid_i && (flit_vc_i == NumVCWidth'(v));
    end
  end

  // VC selection per requester
  always_comb begin
    pref = '0;
    for (int r = 0; r < NumReq; r++) begin
      elig[r]   = 1'b0;
      sel_vc[r] = '0;
      pref      = alloc_pref_vc_i[r*NumVCWidth +: NumVCWidth];
      if (alloc_req_i[r]) begin
        if ((int'(pref) < NumVC) && vc_avail[pref]) begin
          elig[r]   = 1'b1;
          sel_vc[r] = pref;
        end else begin
`ifdef FLOO_VC_ALLOC_STRICT_PREF_EN
          elig[r] = 1'b0;
`else
          // Scan downwards so the lowest allocatable index wins.
          for (int v = NumVC - 1; v >= 0; v--) begin
            if (vc_avail[v]) begin
              elig[r]   = 1'b1;
              sel_vc[r] = NumVCWidth'(v);
            end
          end
`endif
        end
      end
    end
  end

  // Round-robin arbitration starting at ptr_q
  always_comb begin
    gnt_valid = 1'b0;
    win       = '0;
    gnt_vc    = '0;
    rr_idx    = 0;
    cand      = '0;
    for (int i = 0; i < NumReq; i++) begin
      rr_idx = int'(ptr_q) + i;
      if (rr_idx >= NumReq) rr_idx = rr_idx - NumReq;
      cand = ReqIdxW'(rr_idx);
      if (!gnt_valid && elig[cand]) begin
        gnt_valid = 1'b1;
        win       = cand;
        gnt_vc    = sel_vc[cand];
      end
    end
    gnt = '0;
    if (gnt_valid) gnt[win] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) ptr_d = (int'(win) == NumReq - 1) ? '0 : win + 1'b1;

    lock_d = lock_q;
    for (int v = 0; v < NumVC; v++) begin
      if (vc_send[v] && flit_last_i)                    lock_d[v] = 1'b0;
      if (gnt_valid && (gnt_vc == NumVCWidth'(v)))      lock_d[v] = 1'b1;
    end

    // Illegal underflow/overflow hold the counter; assertions flag them.
    for (int v = 0; v < NumVC; v++) begin
      cnt_d[v] = cnt_q[v];
      if (vc_send[v] && !credit_valid_i[v] && (cnt_q[v] != '0))
        cnt_d[v] = cnt_q[v] - 1'b1;
      else if (credit_valid_i[v] && !vc_send[v] && (cnt_q[v] != Depth))
        cnt_d[v] = cnt_q[v] + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int v = 0; v < NumVC; v++) cnt_q[v] <= Depth;
      lock_q <= '0;
      ptr_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      ptr_q  <= ptr_d;
    end
  end

  always_comb begin
    for (int v = 0; v < NumVC; v++)
      credit_counter_o[v*VCDepthWidth +: VCDepthWidth] = cnt_q[v];
  end

  assign vc_locked_o = lock_q;
  assign alloc_gnt_o = rst_ni ? gnt : '0;
  assign alloc_vc_o  = (rst_ni && gnt_valid) ? gnt_vc : '0;

`ifndef SYNTHESIS
  for (genvar gv = 0; gv < NumVC; gv++) begin : g_chk
    a_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(vc_send[gv] && (cnt_q[gv] == '0)));
    a_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(credit_valid_i[gv] && !vc_send[gv] && (cnt_q[gv] == Depth)));
    a_send_unlocked : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(vc_send[gv] && !lock_q[gv]));
  end
`endif

endmodule
